// File: rtl/sid_pkg.sv
// Shared definitions for the SID paddle (POTX/POTY) conditioning path.
package sid_pkg;

    localparam int SID_POT_W      = 8;
    localparam int SID_POT_PERIOD = 512;

    // Filter sequencer: one sample walks IDLE -> MED -> IIR -> OUT.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MED  = 2'd1,
        IIR  = 2'd2,
        OUT  = 2'd3
    } sid_pot_state_e;

    // Unsigned distance between two pot values.
    function automatic logic [SID_POT_W-1:0] pot_abs_diff(
        input logic [SID_POT_W-1:0] a,
        input logic [SID_POT_W-1:0] b
    );
        logic [SID_POT_W-1:0] r;
        if (a >= b) begin
            r = a - b;
        end else begin
            r = b - a;
        end
        return r;
    endfunction

endpackage

// File: rtl/sid_median3.sv
// Combinational median of three 8-bit values, built from comparisons only.
// Ties return the repeated value.
module sid_median3
    import sid_pkg::*;
(
    input  logic [SID_POT_W-1:0] a_i,
    input  logic [SID_POT_W-1:0] b_i,
    input  logic [SID_POT_W-1:0] c_i,
    output logic [SID_POT_W-1:0] med_o
);

    logic [SID_POT_W-1:0] lo_ab_s;
    logic [SID_POT_W-1:0] hi_ab_s;
    logic [SID_POT_W-1:0] hi_c_s;

    // med = max(min(a,b), min(max(a,b), c))
    always_comb begin
        lo_ab_s = a_i;
        hi_ab_s = b_i;
        if (a_i <= b_i) begin
            lo_ab_s = a_i;
            hi_ab_s = b_i;
        end else begin
            lo_ab_s = b_i;
            hi_ab_s = a_i;
        end
        if (hi_ab_s <= c_i) begin
            hi_c_s = hi_ab_s;
        end else begin
            hi_c_s = c_i;
        end
        if (lo_ab_s >= hi_c_s) begin
            med_o = lo_ab_s;
        end else begin
            med_o = hi_c_s;
        end
    end

endmodule

// File: rtl/sid_pot_filter_chk.sv
// Property checker for sid_pot_filter: sample ticks only land in IDLE and the
// accumulator never leaves the scaled 8-bit range.
module sid_pot_filter_chk
    import sid_pkg::*;
#(
    parameter int SHIFT = 2
) (
    input logic                       clk,
    input logic                       rstn,
    input logic                       tick_i,
    input sid_pot_state_e             state_i,
    input logic [SID_POT_W+SHIFT-1:0] acc_i
);

    localparam int                       AW      = SID_POT_W + SHIFT;
    localparam logic [AW-1:0]            ACC_MAX = AW'(255 << SHIFT);

    a_tick_in_idle: assert property (@(posedge clk) disable iff (!rstn)
        tick_i |-> (state_i == IDLE));

    a_acc_in_range: assert property (@(posedge clk) disable iff (!rstn)
        acc_i <= ACC_MAX);

endmodule

// File: rtl/sid_pot_filter.sv
// Paddle value conditioner: periodic sampling, median-of-3 spike rejection,
// first-order IIR smoothing and output hysteresis with full-scale endpoints.
module sid_pot_filter
    import sid_pkg::*;
#(
    parameter int PERIOD = SID_POT_PERIOD,
    parameter int SHIFT  = 2,
    parameter int HYST   = 1
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 clkEn,
    input  logic [SID_POT_W-1:0] iPotVal,
    output logic [SID_POT_W-1:0] oPotVal,
    output logic                 oUpdStb
);

    localparam int             TW        = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam logic [TW-1:0]  TIMER_END = TW'(PERIOD - 1);
    localparam int             AW        = SID_POT_W + SHIFT;
    localparam int             DW        = AW + 1;

    logic [TW-1:0]          timer_q;
    logic [TW-1:0]          timer_d;
    sid_pot_state_e         state_q;
    logic                   primed_q;
    logic [SID_POT_W-1:0]   tap0_q;
    logic [SID_POT_W-1:0]   tap1_q;
    logic [SID_POT_W-1:0]   tap2_q;
    logic [SID_POT_W-1:0]   med_q;
    logic [AW-1:0]          acc_q;
    logic [SID_POT_W-1:0]   pot_q;
    logic                   stb_q;

    logic                   tick_s;
    logic [SID_POT_W-1:0]   med_s;
    logic [DW-1:0]          med_ext_s;
    logic signed [DW-1:0]   diff_s;
    logic signed [DW-1:0]   step_s;
    logic [AW-1:0]          acc_iir_s;
    logic [SID_POT_W-1:0]   acc_int_s;
    logic [SID_POT_W-1:0]   dist_s;
    logic                   upd_s;

    sid_median3 u_median3 (
        .a_i   (tap0_q),
        .b_i   (tap1_q),
        .c_i   (tap2_q),
        .med_o (med_s)
    );

    // Sample timer advances on clkEn only and wraps every PERIOD ticks.
    always_comb begin
        timer_d = timer_q;
        if (clkEn) begin
            if (timer_q == TIMER_END) begin
                timer_d = '0;
            end else begin
                timer_d = timer_q + TW'(1);
            end
        end else begin
            timer_d = timer_q;
        end
    end

    assign tick_s = clkEn & (timer_q == TIMER_END);

    // IIR step: acc + ((med << SHIFT) - acc) >>> SHIFT. The floor shift means
    // an upward approach stalls once the gap is below 2^SHIFT LSBs, while a
    // downward approach always settles exactly on the target.
    always_comb begin
        med_ext_s = DW'(med_q) << SHIFT;
        diff_s    = $signed(med_ext_s) - $signed({1'b0, acc_q});
        step_s    = diff_s >>> SHIFT;
        acc_iir_s = acc_q + step_s[AW-1:0];
    end

    // Output update decision: first sample, hysteresis window, or endpoints.
    always_comb begin
        acc_int_s = acc_q[SHIFT +: SID_POT_W];
        dist_s    = pot_abs_diff(acc_int_s, pot_q);
        if (!primed_q) begin
            upd_s = 1'b1;
        end else if (dist_s > SID_POT_W'(HYST)) begin
            upd_s = 1'b1;
        end else if ((acc_int_s == 8'd0) && (pot_q != 8'd0)) begin
            upd_s = 1'b1;
        end else if ((acc_int_s == 8'd255) && (pot_q != 8'd255)) begin
            upd_s = 1'b1;
        end else begin
            upd_s = 1'b0;
        end
    end

    // Sequencer and filter datapath: one pipeline step per clk.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            timer_q  <= '0;
            state_q  <= IDLE;
            primed_q <= 1'b0;
            tap0_q   <= 8'd0;
            tap1_q   <= 8'd0;
            tap2_q   <= 8'd0;
            med_q    <= 8'd0;
            acc_q    <= '0;
            pot_q    <= 8'd0;
            stb_q    <= 1'b0;
        end else begin
            timer_q <= timer_d;
            stb_q   <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (tick_s) begin
                        if (primed_q) begin
                            tap0_q <= iPotVal;
                            tap1_q <= tap0_q;
                            tap2_q <= tap1_q;
                        end else begin
                            // First sample seeds the whole history so the
                            // output lands directly on the input.
                            tap0_q <= iPotVal;
                            tap1_q <= iPotVal;
                            tap2_q <= iPotVal;
                            acc_q  <= AW'(iPotVal) << SHIFT;
                        end
                        state_q <= MED;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                MED: begin
                    med_q   <= med_s;
                    state_q <= IIR;
                end
                IIR: begin
                    if (primed_q) begin
                        acc_q <= acc_iir_s;
                    end else begin
                        acc_q <= acc_q;
                    end
                    state_q <= OUT;
                end
                OUT: begin
                    if (upd_s) begin
                        pot_q <= acc_int_s;
                        stb_q <= 1'b1;
                    end else begin
                        pot_q <= pot_q;
                    end
                    primed_q <= 1'b1;
                    state_q  <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign oPotVal = pot_q;
    assign oUpdStb = stb_q;

    sid_pot_filter_chk #(
        .SHIFT (SHIFT)
    ) u_chk (
        .clk     (clk),
        .rstn    (rstn),
        .tick_i  (tick_s),
        .state_i (state_q),
        .acc_i   (acc_q)
    );

endmodule
